// File: rtl/conv_operand_sequencer.sv
// conv_operand_sequencer
//   Operand feeder for the multiply-accumulate-hold stage. Keeps a TAPS-entry
//   coefficient kernel and a sliding window of the last TAPS samples. Every
//   accepted sample that leaves the window full starts one pass. A pass
//   presents TAPS (window, coefficient) pairs, one pair per clock.
// Ports
//   Clk, Rst_n                    clock, async active-low reset
//   CoefWe/CoefAddr/CoefData      coefficient write port (IDLE only)
//   SampleValid/SampleReady/Data  sample input handshake
//   Flush                         sync window clear and pass abort
//   x, y                          MAC operands (sample, coefficient)
//   AccumReset                    accumulator clear on the first pair of a pass
//   MacValid, MacLast             live pair, last pair of the pass
//   Busy                          pass in progress
module conv_operand_sequencer #(
    parameter int unsigned TAPS = 7,
    parameter int unsigned DW   = 8,
    parameter int unsigned CW   = $clog2(TAPS)
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          CoefWe,
    input  logic [CW-1:0] CoefAddr,
    input  logic [DW-1:0] CoefData,
    input  logic          SampleValid,
    output logic          SampleReady,
    input  logic [DW-1:0] SampleData,
    input  logic          Flush,
    output logic [DW-1:0] x,
    output logic [DW-1:0] y,
    output logic          AccumReset,
    output logic          MacValid,
    output logic          MacLast,
    output logic          Busy
);

    localparam int unsigned FW = $clog2(TAPS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] idx, idx_next;
    logic [FW-1:0] fill, fill_next;
    logic [DW-1:0] win       [TAPS];
    logic [DW-1:0] win_next  [TAPS];
    logic [DW-1:0] coef      [TAPS];
    logic [DW-1:0] coef_next [TAPS];
    logic [DW-1:0] x_next, y_next;
    logic          accum_reset_next, mac_valid_next, mac_last_next;
    logic          accept;
    logic          coef_wr;

    // Handshake decodes straight from the state register
    assign SampleReady = (state == IDLE) & ~Flush;
    assign Busy        = (state == ISSUE);
    assign accept      = SampleValid & SampleReady;
    assign coef_wr     = CoefWe & (state == IDLE) &
                         ({1'b0, CoefAddr} < (CW + 1)'(TAPS));

    // State, window, kernel and registered MAC outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            fill       <= '0;
            x          <= '0;
            y          <= '0;
            AccumReset <= 1'b1;
            MacValid   <= 1'b0;
            MacLast    <= 1'b0;
            for (int k = 0; k < int'(TAPS); k++) begin
                win[k]  <= '0;
                coef[k] <= '0;
            end
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            fill       <= fill_next;
            x          <= x_next;
            y          <= y_next;
            AccumReset <= accum_reset_next;
            MacValid   <= mac_valid_next;
            MacLast    <= mac_last_next;
            for (int k = 0; k < int'(TAPS); k++) begin
                win[k]  <= win_next[k];
                coef[k] <= coef_next[k];
            end
        end
    end

    // Next state, window shift, kernel write and pair issue
    always_comb begin
        state_next       = state;
        idx_next         = idx;
        fill_next        = fill;
        x_next           = '0;
        y_next           = '0;
        accum_reset_next = 1'b0;
        mac_valid_next   = 1'b0;
        mac_last_next    = 1'b0;
        for (int k = 0; k < int'(TAPS); k++) begin
            win_next[k]  = win[k];
            coef_next[k] = coef[k];
        end

        if (coef_wr) begin
            coef_next[CoefAddr] = CoefData;
        end

        if (Flush) begin
            // Idle outputs stay at their zero defaults; kernel is kept
            state_next = IDLE;
            idx_next   = '0;
            fill_next  = '0;
            for (int k = 0; k < int'(TAPS); k++) begin
                win_next[k] = '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int k = int'(TAPS) - 1; k > 0; k--) begin
                            win_next[k] = win[k-1];
                        end
                        win_next[0] = SampleData;
                        if (fill != FW'(TAPS)) begin
                            fill_next = fill + FW'(1);
                        end
                        // fill_next is TAPS exactly when the window ends up full
                        if (fill_next == FW'(TAPS)) begin
                            state_next = ISSUE;
                            idx_next   = '0;
                        end
                    end
                end
                ISSUE: begin
                    x_next           = win[idx];
                    y_next           = coef[idx];
                    mac_valid_next   = 1'b1;
                    accum_reset_next = (idx == '0);
                    mac_last_next    = (idx == CW'(TAPS - 1));
                    if (idx == CW'(TAPS - 1)) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + CW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            endcase
        end
    end

endmodule
